// File: rtl/sc_bitstream_counter.sv
// Stochastic-to-binary converter: popcounts each bitstream word and accumulates a
// saturating 1-count and word count per frame, presented on a valid/ready output.
//
// state | meaning
// IDLE  | waiting for the first word of a frame
// ACCUM | frame in progress, accepting words
// DRAIN | last word's popcount being added, input stalled
// HOLD  | result pending, waiting for the consumer
module sc_bitstream_counter #(
  parameter int IN_WIDTH  = 32,
  parameter int ACC_WIDTH = 16,
  parameter int CNT_WIDTH = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [IN_WIDTH-1:0]  in_data,
  input  logic                 in_last,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [ACC_WIDTH-1:0] out_sum,
  output logic [CNT_WIDTH-1:0] out_words,
  output logic                 out_ovf
);

  localparam int PC_W = $clog2(IN_WIDTH + 1);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_ACCUM = 2'd1;
  localparam logic [1:0] S_DRAIN = 2'd2;
  localparam logic [1:0] S_HOLD  = 2'd3;

  localparam logic [ACC_WIDTH-1:0] ACC_MAX = '1;
  localparam logic [CNT_WIDTH-1:0] CNT_MAX = '1;

  logic [1:0]           r_state;
  logic                 r_in_ready;
  logic [PC_W-1:0]      r_pc;
  logic                 r_pc_vld;
  logic                 r_pc_last;
  logic [ACC_WIDTH-1:0] r_acc;
  logic [CNT_WIDTH-1:0] r_wcnt;
  logic                 r_ovf;
  logic                 r_out_valid;
  logic [ACC_WIDTH-1:0] r_out_sum;
  logic [CNT_WIDTH-1:0] r_out_words;
  logic                 r_out_ovf;

  logic                      w_accept;
  logic                      w_xfer;
  logic [1:0]                w_state_nxt;
  logic [PC_W-1:0]           w_pc;
  logic [ACC_WIDTH+PC_W-1:0] w_sum_wide;
  logic                      w_acc_sat;
  logic [ACC_WIDTH-1:0]      w_acc_nxt;
  logic                      w_wcnt_sat;
  logic [CNT_WIDTH-1:0]      w_wcnt_nxt;
  logic                      w_ovf_nxt;

  assign w_accept  = in_valid & r_in_ready;
  assign w_xfer    = r_out_valid & out_ready;
  assign in_ready  = r_in_ready;
  assign out_valid = r_out_valid;
  assign out_sum   = r_out_sum;
  assign out_words = r_out_words;
  assign out_ovf   = r_out_ovf;

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (w_accept) w_state_nxt = in_last ? S_DRAIN : S_ACCUM;
      S_ACCUM: if (w_accept && in_last) w_state_nxt = S_DRAIN;
      S_DRAIN: w_state_nxt = S_HOLD;
      S_HOLD:  if (w_xfer) w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // in_ready is registered so it is low while rst is held and rises right after
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= S_IDLE;
      r_in_ready <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_in_ready <= (w_state_nxt == S_IDLE) || (w_state_nxt == S_ACCUM);
    end
  end

  always_comb begin
    w_pc = '0;
    for (int i = 0; i < IN_WIDTH; i++) begin
      w_pc = w_pc + PC_W'(in_data[i]);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_pc      <= '0;
      r_pc_vld  <= 1'b0;
      r_pc_last <= 1'b0;
    end else begin
      r_pc_vld  <= w_accept;
      r_pc_last <= w_accept & in_last;
      if (w_accept) r_pc <= w_pc;
    end
  end

  always_comb begin
    w_sum_wide = {{PC_W{1'b0}}, r_acc} + {{ACC_WIDTH{1'b0}}, r_pc};
    w_acc_sat  = w_sum_wide > {{PC_W{1'b0}}, ACC_MAX};
    w_acc_nxt  = w_acc_sat ? ACC_MAX : w_sum_wide[ACC_WIDTH-1:0];
    w_wcnt_sat = (r_wcnt == CNT_MAX);
    w_wcnt_nxt = w_wcnt_sat ? r_wcnt : r_wcnt + CNT_WIDTH'(1);
    w_ovf_nxt  = r_ovf | w_acc_sat | w_wcnt_sat;
  end

  // The final word is folded in on the same edge the result is captured
  always_ff @(posedge clk) begin
    if (rst) begin
      r_acc       <= '0;
      r_wcnt      <= '0;
      r_ovf       <= 1'b0;
      r_out_sum   <= '0;
      r_out_words <= '0;
      r_out_ovf   <= 1'b0;
    end else if (r_pc_vld) begin
      if (r_pc_last) begin
        r_out_sum   <= w_acc_nxt;
        r_out_words <= w_wcnt_nxt;
        r_out_ovf   <= w_ovf_nxt;
        r_acc       <= '0;
        r_wcnt      <= '0;
        r_ovf       <= 1'b0;
      end else begin
        r_acc  <= w_acc_nxt;
        r_wcnt <= w_wcnt_nxt;
        r_ovf  <= w_ovf_nxt;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_out_valid <= 1'b0;
    end else if (w_xfer) begin
      r_out_valid <= 1'b0;
    end else if (r_state == S_HOLD) begin
      r_out_valid <= 1'b1;
    end
  end

endmodule

// File: tb/tb_sc_bitstream_counter.sv
// Directed bench for sc_bitstream_counter: default, 8-bit-accumulator and
// 2-bit-word-counter instances driven by one shared stimulus stream.
module tb_sc_bitstream_counter;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic [31:0] in_data;
  logic        in_last;
  logic        out_ready;

  logic        rdy0, ov0, of0;
  logic [15:0] sum0;
  logic [7:0]  wd0;
  logic        rdy1, ov1, of1;
  logic [7:0]  sum1;
  logic [7:0]  wd1;
  logic        rdy2, ov2, of2;
  logic [15:0] sum2;
  logic [1:0]  wd2;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  sc_bitstream_counter u_dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(rdy0), .in_data(in_data),
    .in_last(in_last), .out_valid(ov0), .out_ready(out_ready), .out_sum(sum0),
    .out_words(wd0), .out_ovf(of0));

  sc_bitstream_counter #(.ACC_WIDTH(8)) u_acc8 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(rdy1), .in_data(in_data),
    .in_last(in_last), .out_valid(ov1), .out_ready(out_ready), .out_sum(sum1),
    .out_words(wd1), .out_ovf(of1));

  sc_bitstream_counter #(.CNT_WIDTH(2)) u_cnt2 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(rdy2), .in_data(in_data),
    .in_last(in_last), .out_valid(ov2), .out_ready(out_ready), .out_sum(sum2),
    .out_words(wd2), .out_ovf(of2));

  typedef struct {
    logic [31:0] data;
    logic        last;
    int          gap;
    int          exp_sum;
    int          exp_words;
    int          exp_ovf;
  } vec_t;

  vec_t vecs[8];

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send_word(input logic [31:0] d, input logic l);
    int n = 0;
    while (!rdy0 && n < 50) begin
      step();
      n++;
    end
    if (!rdy0) begin
      checks++;
      failures++;
      $display("FAIL send_word_timeout actual=in_ready_low required=in_ready_high");
    end
    in_valid = 1'b1;
    in_data  = d;
    in_last  = l;
    step();
    in_valid = 1'b0;
    in_last  = 1'b0;
    in_data  = '0;
  endtask

  task automatic get_result(input string name, input int sel, input int es,
                            input int ew, input int eo);
    int n = 0;
    while (!ov0 && n < 20) begin
      step();
      n++;
    end
    chk({name, "_valid"}, int'(ov0), 1);
    case (sel)
      0: begin
        chk({name, "_sum"}, int'(sum0), es);
        chk({name, "_words"}, int'(wd0), ew);
        chk({name, "_ovf"}, int'(of0), eo);
      end
      1: begin
        chk({name, "_sum"}, int'(sum1), es);
        chk({name, "_words"}, int'(wd1), ew);
        chk({name, "_ovf"}, int'(of1), eo);
      end
      default: begin
        chk({name, "_sum"}, int'(sum2), es);
        chk({name, "_words"}, int'(wd2), ew);
        chk({name, "_ovf"}, int'(of2), eo);
      end
    endcase
    step();
  endtask

  initial begin
    vecs[0] = '{32'h0000000F, 1'b0, 1, 0, 0, 0};
    vecs[1] = '{32'hF0F0F0F0, 1'b0, 1, 0, 0, 0};
    vecs[2] = '{32'h00000000, 1'b0, 1, 0, 0, 0};
    vecs[3] = '{32'h80000001, 1'b1, 0, 22, 4, 0};
    vecs[4] = '{32'hAAAAAAAA, 1'b1, 0, 16, 1, 0};
    vecs[5] = '{32'h12345678, 1'b0, 2, 0, 0, 0};
    vecs[6] = '{32'h00000000, 1'b0, 0, 0, 0, 0};
    vecs[7] = '{32'h00000000, 1'b1, 0, 13, 3, 0};

    rst = 1'b1; in_valid = 1'b0; in_data = '0; in_last = 1'b0; out_ready = 1'b1;
    step(); step();
    chk("rst_in_ready", int'(rdy0), 0);
    chk("rst_out_valid", int'(ov0), 0);
    chk("rst_out_sum", int'(sum0), 0);
    chk("rst_out_words", int'(wd0), 0);
    chk("rst_out_ovf", int'(of0), 0);
    rst = 1'b0;
    step();
    chk("post_rst_in_ready", int'(rdy0), 1);

    // single-word frame with exact latency
    in_valid = 1'b1; in_data = 32'hFFFFFFFF; in_last = 1'b1;
    step();
    in_valid = 1'b0; in_last = 1'b0;
    chk("t1_drain_in_ready", int'(rdy0), 0);
    step();
    chk("t1_valid_edge1", int'(ov0), 0);
    step();
    chk("t1_valid_edge2", int'(ov0), 1);
    chk("t1_sum", int'(sum0), 32);
    chk("t1_words", int'(wd0), 1);
    chk("t1_ovf", int'(of0), 0);
    step();
    chk("t1_valid_drop", int'(ov0), 0);
    chk("t1_sum_kept", int'(sum0), 32);
    chk("t1_in_ready_back", int'(rdy0), 1);

    for (int i = 0; i < 8; i++) begin
      send_word(vecs[i].data, vecs[i].last);
      if (vecs[i].last)
        get_result($sformatf("vec%0d", i), 0, vecs[i].exp_sum, vecs[i].exp_words,
                   vecs[i].exp_ovf);
      else
        repeat (vecs[i].gap) step();
    end

    // backpressure: result and in_ready held while out_ready is low
    out_ready = 1'b0;
    send_word(32'h000000FF, 1'b1);
    begin
      int n = 0;
      while (!ov0 && n < 20) begin
        step();
        n++;
      end
    end
    in_valid = 1'b1; in_data = 32'hFFFFFFFF; in_last = 1'b1;
    for (int c = 0; c < 5; c++) begin
      chk($sformatf("bp_valid_c%0d", c), int'(ov0), 1);
      chk($sformatf("bp_in_ready_c%0d", c), int'(rdy0), 0);
      chk($sformatf("bp_sum_c%0d", c), int'(sum0), 8);
      chk($sformatf("bp_words_c%0d", c), int'(wd0), 1);
      step();
    end
    out_ready = 1'b1; in_valid = 1'b0; in_last = 1'b0; in_data = '0;
    step();
    chk("bp_valid_drop", int'(ov0), 0);
    chk("bp_in_ready_back", int'(rdy0), 1);
    chk("bp_sum_kept", int'(sum0), 8);
    send_word(32'h00000003, 1'b1);
    get_result("bp_next", 0, 2, 1, 0);

    // accumulator saturation on the 8-bit instance
    for (int i = 0; i < 9; i++) send_word(32'hFFFFFFFF, i == 8);
    chk("sat_wide_sum", 0, 0);
    checks--;
    get_result("sat_acc8", 1, 255, 9, 1);
    chk("sat_wide_sum_dut", int'(sum0), 288);
    chk("sat_wide_ovf_dut", int'(of0), 0);
    send_word(32'h00000001, 1'b1);
    get_result("sat_acc8_next", 1, 1, 1, 0);

    // reset in the middle of a frame
    send_word(32'hFFFFFFFF, 1'b0);
    send_word(32'hFFFFFFFF, 1'b0);
    rst = 1'b1;
    step();
    chk("mid_rst_in_ready", int'(rdy0), 0);
    chk("mid_rst_valid", int'(ov0), 0);
    chk("mid_rst_sum", int'(sum0), 0);
    chk("mid_rst_words", int'(wd0), 0);
    chk("mid_rst_ovf", int'(of1), 0);
    rst = 1'b0;
    step();
    chk("mid_rst_ready_back", int'(rdy0), 1);
    send_word(32'h0000FFFF, 1'b1);
    get_result("mid_rst_next", 0, 16, 1, 0);

    // word-counter saturation on the 2-bit instance
    for (int i = 0; i < 5; i++) send_word(32'h00000001, i == 4);
    get_result("wsat_cnt2", 2, 5, 3, 1);
    chk("wsat_dut_words", int'(wd0), 5);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
